// File: rtl/ab_window_monitor_pkg.sv
// ab_mon_pkg: shared types and constants for the signal_a/signal_b window monitor.
//   state_t          : window FSM states (IDLE, OPEN, DEAD)
//   ST_VIOL, ST_TOUT : bit positions inside the 2-bit sticky status word
package ab_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no window open; waiting for signal_a
        OPEN = 2'd1,   // window open; signal_b must stay low
        DEAD = 2'd2    // window already failed; waiting for the next signal_a
    } state_t;

    localparam int ST_VIOL = 0;
    localparam int ST_TOUT = 1;

endpackage

// File: rtl/ab_window_monitor_if.sv
// ab_window_monitor_if: groups the monitored signals, controls and report outputs.
//   signal_a, signal_b : monitored producer signals
//   clr, irq_en        : synchronous status/counter clear, interrupt enable
//   pass_pulse, fail_pulse, tout_pulse : one-cycle event reports
//   status[1:0]        : sticky flags ([0] violation, [1] timeout)
//   pass_cnt, fail_cnt : saturating window counters, CNT_W bits
//   irq                : registered interrupt
// The master modport drives the inputs and observes the reports; the slave
// modport is the monitor itself.
interface ab_window_monitor_if #(parameter int CNT_W = 8);

    logic             signal_a;
    logic             signal_b;
    logic             clr;
    logic             irq_en;
    logic             pass_pulse;
    logic             fail_pulse;
    logic             tout_pulse;
    logic [1:0]       status;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             irq;

    modport master (
        output signal_a, signal_b, clr, irq_en,
        input  pass_pulse, fail_pulse, tout_pulse, status, pass_cnt, fail_cnt, irq
    );

    modport slave (
        input  signal_a, signal_b, clr, irq_en,
        output pass_pulse, fail_pulse, tout_pulse, status, pass_cnt, fail_cnt, irq
    );

endinterface

// File: rtl/ab_window_monitor_sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear, applied before the increment of the same cycle
//   inc        : count one event
//   count      : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] base;

    // Clear first, so a clear and an event on the same cycle leave a count of one.
    assign base = clr ? '0 : count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (base != '1)) begin
            count <= base + 1'b1;
        end else begin
            count <= base;
        end
    end

endmodule

// File: rtl/ab_window_monitor.sv
// ab_window_monitor: checks that once signal_a is sampled high, signal_b stays low
// on every following cycle up to and including the next signal_a.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : ab_window_monitor_if slave (inputs, pulses, status, counters, irq)
// Every report is registered: an input sampled at edge t is reported in cycle t+1.
// MAX_GAP = 0 disables the gap timeout.
module ab_window_monitor
    import ab_mon_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 16,
    parameter int MAX_GAP = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    ab_window_monitor_if.slave   bus
);

    localparam logic             TOUT_EN  = (MAX_GAP != 0);
    // Only meaningful when TOUT_EN is set.
    localparam logic [GAP_W-1:0] TOUT_LEN = GAP_W'(MAX_GAP - 1);

    state_t           state, state_nxt;
    logic [GAP_W-1:0] len, len_nxt;
    logic             pass_nxt, fail_nxt, tout_nxt;

    logic             pass_q, fail_q, tout_q, irq_q;
    logic [1:0]       status_q;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;

    // ------------------------------------------------------------------
    // Window FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len   <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Window FSM: next state and event decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        len_nxt   = len;
        pass_nxt  = 1'b0;
        fail_nxt  = 1'b0;
        tout_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                // signal_b is not checked on the opening cycle.
                if (bus.signal_a) begin
                    state_nxt = OPEN;
                    len_nxt   = '0;
                end
            end

            OPEN: begin
                if (bus.signal_b && bus.signal_a) begin
                    // Old window fails, the same signal_a opens a new one.
                    fail_nxt = 1'b1;
                    len_nxt  = '0;
                end else if (bus.signal_b) begin
                    // One fail per window; ignore signal_b until the next signal_a.
                    fail_nxt  = 1'b1;
                    state_nxt = DEAD;
                end else if (bus.signal_a) begin
                    // Closing signal_a is also the opening signal_a of the next window.
                    pass_nxt = 1'b1;
                    len_nxt  = '0;
                end else if (TOUT_EN && (len == TOUT_LEN)) begin
                    tout_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (len != '1) begin
                    len_nxt = len + 1'b1;
                end
            end

            DEAD: begin
                // signal_b on the reopening cycle is ignored.
                if (bus.signal_a) begin
                    state_nxt = OPEN;
                    len_nxt   = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
                len_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered pulses, sticky status and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            tout_q   <= 1'b0;
            status_q <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            pass_q   <= pass_nxt;
            fail_q   <= fail_nxt;
            tout_q   <= tout_nxt;
            // clr wipes the old flags; an event on the same cycle still lands.
            status_q[ST_VIOL] <= (status_q[ST_VIOL] & ~bus.clr) | fail_nxt;
            status_q[ST_TOUT] <= (status_q[ST_TOUT] & ~bus.clr) | tout_nxt;
            // Built from the registered status, so irq trails status by a cycle.
            irq_q    <= (status_q != 2'b00) & bus.irq_en;
        end
    end

    // ------------------------------------------------------------------
    // Saturating window counters (a timeout is not a failed window)
    // ------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr),
        .inc   (pass_nxt),
        .count (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr),
        .inc   (fail_nxt),
        .count (fail_cnt)
    );

    assign bus.pass_pulse = pass_q;
    assign bus.fail_pulse = fail_q;
    assign bus.tout_pulse = tout_q;
    assign bus.status     = status_q;
    assign bus.pass_cnt   = pass_cnt;
    assign bus.fail_cnt   = fail_cnt;
    assign bus.irq        = irq_q;

endmodule

// File: tb/tb_ab_window_monitor.sv
// tb_ab_window_monitor: directed bench for ab_window_monitor.
// dut0 uses the default parameters (no timeout, 8-bit counters); dut1 uses
// MAX_GAP = 4 and 2-bit counters for the timeout and saturation cases.
// A window-level reference model predicts every output each cycle; literal
// checks at key points pin the model to hand-computed values.
module tb_ab_window_monitor;

    localparam int GAP_MAX = 65535;

    bit   clk;
    logic reset;

    ab_window_monitor_if #(.CNT_W(8)) bus0 ();
    ab_window_monitor_if #(.CNT_W(2)) bus1 ();

    ab_window_monitor #(.CNT_W(8), .GAP_W(16), .MAX_GAP(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    ab_window_monitor #(.CNT_W(2), .GAP_W(16), .MAX_GAP(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks windows, not FSM encodings.
    // ------------------------------------------------------------------
    typedef struct {
        bit       in_win;    // a window has been opened and has not timed out
        bit       failed;    // current window already reported a fail
        int       gap;       // checked cycles since the window opened
        int       pass_n;
        int       fail_n;
        bit [1:0] st;
        bit       pp, fp, tp;
        bit       irq;
    } mdl_t;

    function automatic mdl_t step(input mdl_t m, input bit a, input bit b, input bit clr,
                                  input bit irq_en, input int max_gap, input int cnt_max);
        mdl_t r = m;
        r.pp  = 0;
        r.fp  = 0;
        r.tp  = 0;
        r.irq = (m.st != 0) && irq_en;
        if (clr) begin
            r.st     = 0;
            r.pass_n = 0;
            r.fail_n = 0;
        end
        if (!m.in_win || m.failed) begin
            if (a) begin
                r.in_win = 1;
                r.failed = 0;
                r.gap    = 0;
            end
        end else if (b) begin
            r.fp = 1;
            if (a) r.gap = 0;
            else   r.failed = 1;
        end else if (a) begin
            r.pp  = 1;
            r.gap = 0;
        end else if (max_gap != 0 && m.gap == max_gap - 1) begin
            r.tp     = 1;
            r.in_win = 0;
        end else if (m.gap < GAP_MAX) begin
            r.gap = m.gap + 1;
        end
        if (r.fp) begin
            r.st[0]  = 1;
            r.fail_n = (r.fail_n < cnt_max) ? r.fail_n + 1 : cnt_max;
        end
        if (r.pp) r.pass_n = (r.pass_n < cnt_max) ? r.pass_n + 1 : cnt_max;
        if (r.tp) r.st[1] = 1;
        return r;
    endfunction

    mdl_t m0, m1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= '{default: 0};
            m1 <= '{default: 0};
        end else begin
            m0 <= step(m0, bus0.signal_a, bus0.signal_b, bus0.clr, bus0.irq_en, 0, 255);
            m1 <= step(m1, bus1.signal_a, bus1.signal_b, bus1.clr, bus1.irq_en, 4, 3);
        end
    end

    // Compare process: outputs are stable around the falling edge.
    always @(negedge clk) begin
        check("dut0.pass_pulse", 32'(bus0.pass_pulse), 32'(m0.pp));
        check("dut0.fail_pulse", 32'(bus0.fail_pulse), 32'(m0.fp));
        check("dut0.tout_pulse", 32'(bus0.tout_pulse), 32'(m0.tp));
        check("dut0.status",     32'(bus0.status),     32'(m0.st));
        check("dut0.pass_cnt",   32'(bus0.pass_cnt),   32'(m0.pass_n));
        check("dut0.fail_cnt",   32'(bus0.fail_cnt),   32'(m0.fail_n));
        check("dut0.irq",        32'(bus0.irq),        32'(m0.irq));
        check("dut1.pass_pulse", 32'(bus1.pass_pulse), 32'(m1.pp));
        check("dut1.fail_pulse", 32'(bus1.fail_pulse), 32'(m1.fp));
        check("dut1.tout_pulse", 32'(bus1.tout_pulse), 32'(m1.tp));
        check("dut1.status",     32'(bus1.status),     32'(m1.st));
        check("dut1.pass_cnt",   32'(bus1.pass_cnt),   32'(m1.pass_n));
        check("dut1.fail_cnt",   32'(bus1.fail_cnt),   32'(m1.fail_n));
        check("dut1.irq",        32'(bus1.irq),        32'(m1.irq));
    end

    // Apply one input vector and return just after the edge that samples it.
    task automatic drive0(input bit a, input bit b, input bit c);
        @(negedge clk);
        bus0.signal_a = a;
        bus0.signal_b = b;
        bus0.clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input bit a, input bit b, input bit c);
        @(negedge clk);
        bus1.signal_a = a;
        bus1.signal_b = b;
        bus1.clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.signal_a = 0; bus0.signal_b = 0; bus0.clr = 0; bus0.irq_en = 0;
        bus1.signal_a = 0; bus1.signal_b = 0; bus1.clr = 0; bus1.irq_en = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        drive0(0, 0, 0);
        check("reset status",   32'(bus0.status),   0);
        check("reset pass_cnt", 32'(bus0.pass_cnt), 0);
        check("reset irq",      32'(bus0.irq),      0);

        // Clean window: open, four quiet cycles, close
        drive0(1, 0, 0);
        repeat (4) drive0(0, 0, 0);
        drive0(1, 0, 0);
        check("clean pass_pulse", 32'(bus0.pass_pulse), 1);
        check("clean pass_cnt",   32'(bus0.pass_cnt),   1);
        check("clean status",     32'(bus0.status),     0);
        drive0(0, 0, 0);
        check("clean pulse width", 32'(bus0.pass_pulse), 0);
        check("clean irq",         32'(bus0.irq),       0);

        // Violation, then b still high across the next signal_a
        bus0.irq_en = 1;
        drive0(1, 0, 0);
        check("viol prior pass_cnt", 32'(bus0.pass_cnt), 2);
        drive0(0, 0, 0);
        drive0(0, 1, 0);
        check("viol first fail", 32'(bus0.fail_pulse), 1);
        drive0(1, 1, 0);
        check("viol reopen no pulse", 32'(bus0.fail_pulse), 0);
        drive0(0, 1, 0);
        check("viol second fail", 32'(bus0.fail_pulse), 1);
        check("viol fail_cnt",    32'(bus0.fail_cnt),   2);
        check("viol status",      32'(bus0.status),     1);
        drive0(0, 0, 0);
        check("viol irq", 32'(bus0.irq), 1);

        // a and b together while OPEN: fail, stay OPEN, then pass 3 cycles later
        drive0(1, 0, 0);
        drive0(0, 0, 0);
        drive0(1, 1, 0);
        check("simul fail_pulse", 32'(bus0.fail_pulse), 1);
        check("simul fail_cnt",   32'(bus0.fail_cnt),   3);
        drive0(0, 0, 0);
        drive0(0, 0, 0);
        drive0(1, 0, 0);
        check("simul then pass", 32'(bus0.pass_pulse), 1);
        check("simul pass_cnt",  32'(bus0.pass_cnt),   3);

        // irq_en low masks irq but keeps status
        bus0.irq_en = 0;
        drive0(0, 0, 0);
        check("mask irq",    32'(bus0.irq),    0);
        check("mask status", 32'(bus0.status), 1);

        // clr alone
        drive0(0, 0, 1);
        check("clr status",   32'(bus0.status),   0);
        check("clr pass_cnt", 32'(bus0.pass_cnt), 0);
        check("clr fail_cnt", 32'(bus0.fail_cnt), 0);

        // Async reset mid-window
        drive0(0, 1, 0);
        check("pre-reset status", 32'(bus0.status), 1);
        drive0(1, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        bus0.signal_a = 0;
        bus0.signal_b = 0;
        #1;
        check("async status",     32'(bus0.status),     0);
        check("async fail_cnt",   32'(bus0.fail_cnt),   0);
        check("async pass_cnt",   32'(bus0.pass_cnt),   0);
        check("async fail_pulse", 32'(bus0.fail_pulse), 0);
        @(negedge clk);
        reset = 1'b0;
        drive0(0, 1, 0);
        check("post-reset b ignored", 32'(bus0.fail_pulse), 0);
        drive0(0, 1, 0);
        check("post-reset b ignored 2", 32'(bus0.fail_pulse), 0);
        drive0(1, 0, 0);
        drive0(0, 1, 0);
        check("post-reset new window fails", 32'(bus0.fail_pulse), 1);
        drive0(0, 0, 0);

        // Timeout on dut1 (MAX_GAP = 4)
        drive1(1, 0, 0);
        repeat (3) begin
            drive1(0, 0, 0);
            check("tout not yet", 32'(bus1.tout_pulse), 0);
        end
        drive1(0, 0, 0);
        check("tout pulse",  32'(bus1.tout_pulse), 1);
        check("tout status", 32'(bus1.status),     2);
        drive1(0, 1, 0);
        check("tout idle no fail", 32'(bus1.fail_pulse), 0);
        check("tout not counted",  32'(bus1.fail_cnt),   0);

        // Saturation with 2-bit counters, then clr together with a fail
        repeat (5) begin
            drive1(1, 0, 0);
            drive1(0, 1, 0);
        end
        check("sat fail_cnt", 32'(bus1.fail_cnt), 3);
        check("sat status",   32'(bus1.status),   3);
        drive1(1, 0, 0);
        drive1(0, 1, 1);
        check("clr+fail fail_cnt", 32'(bus1.fail_cnt), 1);
        check("clr+fail status",   32'(bus1.status),   1);
        drive1(0, 0, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ab_window_monitor.md
Name: ab_window_monitor

Overview:
- Synthesizable on-chip checker downstream of the signal_a/signal_b producer. It enforces one rule: after signal_a is sampled high, signal_b must stay low on every following cycle up to and including the next signal_a.
- Reports each window as a pass or a fail. Also reports optional gap timeouts, keeps sticky status, keeps saturating counters and raises an interrupt, so the rule is checked in silicon as well as in simulation.

Parameters:
- CNT_W, 8: width of pass_cnt and fail_cnt.
- GAP_W, 16: width of the window-length counter.
- MAX_GAP, 0: number of consecutive checked cycles without signal_a before a timeout is raised. 0 disables the timeout.

Ports:
- clk  in  1  single clock; all sampling on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- signal_a  in  1  window open/close marker.
- signal_b  in  1  must be low inside a window.
- clr  in  1  synchronous; clears sticky status and counters.
- irq_en  in  1  interrupt enable.
- pass_pulse  out  1  one-cycle pulse: a window closed cleanly.
- fail_pulse  out  1  one-cycle pulse: signal_b was seen high inside a window.
- tout_pulse  out  1  one-cycle pulse: gap timeout.
- status  out  2  sticky flags; [0] = violation seen, [1] = timeout seen.
- pass_cnt  out  CNT_W  saturating count of passed windows.
- fail_cnt  out  CNT_W  saturating count of failed windows.
- irq  out  1  registered; equals (status != 0) & irq_en.

Behaviour:
- Reset: the clock is clk and the reset is reset, asynchronous and active-high. While reset is high:
  - state = IDLE and len = 0;
  - all pulses = 0, status = 0, both counters = 0, irq = 0.
  - Reset mid-window abandons the window and reports nothing.
- Timing: inputs are sampled at posedge t. The resulting pulses, status and counters are registered at posedge t and are valid during cycle t+1. Latency is 1 cycle; each pulse is exactly one cycle wide.
- State machine (states IDLE, OPEN, DEAD). Priority within OPEN is top to bottom.
  - IDLE, a=1: go to OPEN, len = 0. signal_b is not checked on the opening cycle.
  - OPEN, b=1 and a=1: fail_pulse. The old window fails and a new one opens: stay OPEN, len = 0.
  - OPEN, b=1 and a=0: fail_pulse, go to DEAD. At most one fail is reported per window.
  - OPEN, b=0 and a=1: pass_pulse, stay OPEN, len = 0. The closing a is also the opening a of the next window.
  - OPEN, a=0 and b=0: len = len + 1, saturating at all-ones.
  - OPEN timeout: if MAX_GAP != 0 and len == MAX_GAP-1 on a cycle with a=0 and b=0, raise tout_pulse and go to IDLE.
  - DEAD, a=1: go to OPEN, len = 0. The b value on this cycle is ignored.
  - DEAD, otherwise: stay DEAD; further b highs produce no pulses.
- Status and counters:
  - fail_pulse sets status[0]; tout_pulse sets status[1]. A timeout is not counted in fail_cnt.
  - pass_cnt and fail_cnt increment on their pulses and hold at 2^CNT_W-1.
- clr:
  - clr alone: status = 0 and both counters = 0 on the next cycle.
  - clr on the same cycle as an event: the clear is applied first and then the event, so the counter reads 1 and the matching status bit is 1.
  - clr never changes the FSM state or len.
- irq: recomputed every cycle from the registered status and irq_en. Deasserting irq_en masks irq; it does not clear status.

Decomposition:
- Package ab_mon_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, OPEN, DEAD};
  - status bit index localparams ST_VIOL = 0, ST_TOUT = 1.
- One sub-module is natural: sat_counter, parameterised by width, with inc and clr inputs and clear-then-increment ordering. It is instantiated twice (pass_cnt, fail_cnt). The window-length counter is inline.

Test Plan:
- Clean windows, 10 ns clock, reset released at 10 ns: a high at 20 ns and at 70 ns, b held low throughout. Expect pass_pulse at 80 ns, pass_cnt = 1, status = 0, irq = 0.
- Violation: a at 100 ns, b high from 120 ns, next a at 130 ns with b still high. Expect:
  - fail_pulse for the b sample at 120 ns;
  - a second fail_pulse for the b sample at 140 ns (the window opened at 130 ns);
  - fail_cnt = 2, status = 01, irq = 1 when irq_en = 1.
- Simultaneous a and b while OPEN: expect one fail_pulse and the state staying OPEN. Then b low and a high 3 cycles later: expect pass_pulse.
- Timeout with MAX_GAP = 4: a once, then a = b = 0 for 4 cycles. Expect tout_pulse on the 4th cycle, status = 10, state IDLE. A later b = 1 produces no pulse.
- Saturation and clear with CNT_W = 2: drive 5 failed windows. Expect fail_cnt to hold at 3. Then clr on the same cycle as a fail: expect fail_cnt = 1 and status[0] = 1.
- Asynchronous reset mid-window: assert reset between clock edges while OPEN. Expect all outputs to go to 0 immediately, with no pulse after release until a new a opens a window.
